// File: rtl/apu_pkg.sv
// apu_pkg: shared APU audio types and I2S timing constants.
package apu_pkg;
    typedef logic signed [15:0] sample_t;
    localparam int CLK_PER_FRAME = 1024;
    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_BCLK_DIV  = 16;
endpackage

// File: rtl/i2s_timing.sv
// i2s_timing: bclk divider and frame bit counter; emits wrap/frame-start events
// and the registered bclk/lrclk.
module i2s_timing import apu_pkg::*; #(
    parameter int BCLK_DIV  = I2S_BCLK_DIV,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable_i,
    output logic                             wrap_o,
    output logic                             frame_start_o,
    output logic [$clog2(2*SLOT_BITS)-1:0]   bit_nx_o,
    output logic                             bclk_o,
    output logic                             lrclk_o
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = $clog2(BCLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          bclk_q, bclk_d, lrclk_q, lrclk_d;

    // Parking at the last position makes the first enabled cycle a frame start.
    always_comb begin
        wrap_o        = enable_i && div_q == DW'(BCLK_DIV - 1);
        frame_start_o = wrap_o && bit_q == BW'(FRAME - 1);
        bit_nx_o      = bit_q == BW'(FRAME - 1) ? '0 : bit_q + BW'(1);
        div_d         = !enable_i ? DW'(BCLK_DIV - 1) : wrap_o ? '0 : div_q + DW'(1);
        bit_d         = !enable_i ? BW'(FRAME - 1) : wrap_o ? bit_nx_o : bit_q;
        bclk_d        = enable_i && !wrap_o && (div_q == DW'(BCLK_DIV / 2 - 1) || bclk_q);
        lrclk_d       = enable_i && (wrap_o ? bit_nx_o >= BW'(SLOT_BITS) : lrclk_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= DW'(BCLK_DIV - 1);
            bit_q   <= BW'(FRAME - 1);
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lrclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo sample holding register and I2S serialiser; its frame start
// is the sample_strobe that paces the upstream APU.
module i2s_tx import apu_pkg::*; #(
    parameter int BCLK_DIV  = I2S_BCLK_DIV,
    parameter int SLOT_BITS = I2S_SLOT_BITS,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_left,
    input  logic [DATA_BITS-1:0] in_right,
    output logic                 in_ready,
    output logic                 sample_strobe,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata,
    output logic                 underrun,
    input  logic                 underrun_clr
);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int XW = $clog2(DATA_BITS);

    logic                 wrap, frame_start, accept;
    logic [BW-1:0]        bit_nx, pos;
    logic [XW-1:0]        idx;
    logic [DATA_BITS-1:0] word;
    logic                 hold_full_q, hold_full_d, strobe_q, strobe_d;
    logic                 sdata_q, sdata_d, underrun_q, underrun_d;
    logic [DATA_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_BITS-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;

    i2s_timing #(.BCLK_DIV(BCLK_DIV), .SLOT_BITS(SLOT_BITS)) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .wrap_o        (wrap),
        .frame_start_o (frame_start),
        .bit_nx_o      (bit_nx),
        .bclk_o        (i2s_bclk),
        .lrclk_o       (i2s_lrclk)
    );

    always_comb begin
        accept      = in_valid && !hold_full_q;
        hold_full_d = accept || (hold_full_q && !frame_start);
        hold_l_d    = accept ? in_left : hold_l_q;
        hold_r_d    = accept ? in_right : hold_r_q;
        frame_l_d   = frame_start ? (hold_full_q ? hold_l_q : '0) : frame_l_q;
        frame_r_d   = frame_start ? (hold_full_q ? hold_r_q : '0) : frame_r_q;
        strobe_d    = frame_start;
        underrun_d  = (frame_start && !hold_full_q) || (underrun_q && !underrun_clr);
        pos         = bit_nx >= BW'(SLOT_BITS) ? bit_nx - BW'(SLOT_BITS) : bit_nx;
        word        = bit_nx >= BW'(SLOT_BITS) ? frame_r_q : frame_l_q;
        idx         = XW'(BW'(DATA_BITS) - pos);
        // Slot position 0 is the I2S one-bit delay; the word follows MSB first.
        sdata_d     = enable && (wrap ? pos != '0 && pos <= BW'(DATA_BITS) && word[idx] : sdata_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            strobe_q    <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            strobe_q    <= strobe_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
        end
    end

    assign in_ready      = !hold_full_q;
    assign sample_strobe = strobe_q;
    assign i2s_sdata     = sdata_q;
    assign underrun      = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed frame table plus hand sequences for underrun, reset and park.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, underrun_clr;
    logic [15:0] in_left, in_right;
    logic        in_ready, sample_strobe, i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        full;
        logic        ur;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_left       (in_left),
        .in_right      (in_right),
        .in_ready      (in_ready),
        .sample_strobe (sample_strobe),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entered on a strobe cycle; returns on the strobe cycle of the next frame.
    task automatic run_frame(input logic [15:0] el, input logic [15:0] er, input logic ef,
                             input logic eur, input logic np, input logic [15:0] nl,
                             input logic [15:0] nr);
        logic [63:0] got, lr, exp;
        int          rises, spbad, stx, rdy, last;
        logic        prev;
        exp = ef ? {1'b0, el, 15'h0, 1'b0, er, 15'h0} : 64'h0;
        chk("frame strobe", 64'(sample_strobe), 64'd1);
        chk("strobe in_ready", 64'(in_ready), 64'd1);
        chk("underrun at strobe", 64'(underrun), 64'(eur));
        in_valid = np;
        in_left  = nl;
        in_right = nr;
        got = '0; lr = '0; rises = 0; spbad = 0; stx = 0; rdy = 0; last = 0;
        prev = i2s_bclk;
        for (int c = 1; c < 1024; c++) begin
            step();
            if (sample_strobe) stx++;
            if (np && in_ready) rdy++;
            if (i2s_bclk && !prev) begin
                if (rises > 0 && c - last != 16) spbad++;
                last  = c;
                got   = {got[62:0], i2s_sdata};
                lr    = {lr[62:0], i2s_lrclk};
                rises++;
            end
            prev = i2s_bclk;
        end
        step();
        chk("strobe spacing 1024", 64'(sample_strobe), 64'd1);
        chk("serial bits", got, exp);
        chk("lrclk pattern", lr, {32'h0, 32'hFFFF_FFFF});
        chk("bclk rises", 64'(rises), 64'd64);
        chk("bclk period", 64'(spbad), 64'd0);
        chk("extra strobe", 64'(stx), 64'd0);
        chk("in_ready after accept", 64'(rdy), 64'd0);
    endtask

    initial begin
        logic quiet;
        vt[0] = '{16'h8001, 16'h7FFE, 1'b1, 1'b0};
        vt[1] = '{16'h1234, 16'hABCD, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[4] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b1};
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1};
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; underrun_clr = 1'b0;
        in_left = '0; in_right = '0;
        repeat (3) step();
        chk("reset outputs", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe, underrun, in_ready}), 64'b000001);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            step();
            if (i2s_bclk || i2s_lrclk || i2s_sdata || sample_strobe || !in_ready || underrun) quiet = 1'b0;
        end
        chk("parked quiet", 64'(quiet), 64'd1);

        in_valid = 1'b1; in_left = vt[0].l; in_right = vt[0].r;
        step();
        in_valid = 1'b0;
        chk("in_ready after push", 64'(in_ready), 64'd0);
        enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++)
            run_frame(vt[i].l, vt[i].r, vt[i].full, vt[i].ur, vt[i+1].full, vt[i+1].l, vt[i+1].r);

        chk("underrun sticky", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("underrun_clr", 64'(underrun), 64'd0);
        repeat (1022) step();
        chk("underrun stays clear", 64'(underrun), 64'd0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("strobe with clr", 64'(sample_strobe), 64'd1);
        chk("set beats clr", 64'(underrun), 64'd1);

        in_valid = 1'b1; in_left = 16'h1111; in_right = 16'h2222;
        step();
        in_valid = 1'b0;
        chk("hold full mid-frame", 64'(in_ready), 64'd0);
        repeat (644) step();
        chk("lrclk at bit 40", 64'(i2s_lrclk), 64'd1);
        rst_n = 1'b0; enable = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid-frame reset", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe, underrun, in_ready}), 64'b000001);
        repeat (3) step();
        enable = 1'b1;
        step();
        run_frame(16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

        repeat (330) step();
        chk("bclk high at bit 20", 64'(i2s_bclk), 64'd1);
        enable = 1'b0;
        step();
        chk("park on disable", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe}), 64'd0);
        in_valid = 1'b1; in_left = 16'h0F0F; in_right = 16'hF0F0;
        step();
        in_valid = 1'b0;
        chk("push while parked", 64'(in_ready), 64'd0);
        quiet = 1'b1;
        for (int i = 0; i < 98; i++) begin
            step();
            if (i2s_bclk || i2s_lrclk || i2s_sdata || sample_strobe) quiet = 1'b0;
        end
        chk("quiet while parked", 64'(quiet), 64'd1);
        enable = 1'b1;
        step();
        run_frame(16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
